// File: rtl/inv_key_scheduler.sv
// Iterative AES-128 key expander: one KeyGeneration step per cycle fills a
// round-key register file, then streams round keys last-to-first over valid/ready.
// Optional build macro INV_KEY_CACHE_EN: remembers the last fully expanded key
// and skips expansion when the same key is started again.
module inv_key_scheduler #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KW         = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_data,
  output logic [3:0]    rk_round,
  output logic          rk_last
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] TOP_IDX  = CW'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One AES-128 key-schedule round: RotWord, SubWord, Rcon, then word chaining.
  function automatic logic [127:0] key_gen(input logic [3:0] rc, input logic [127:0] k);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(rc), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   ptr_m1_c;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [KW-1:0]   data_q, data_d;
  logic [3:0]      round_q, round_d;
  logic            last_q, last_d;
  logic [KW-1:0]   rk_q [0:NUM_ROUNDS];
  logic [KW-1:0]   kg_c;
  logic            wr_en_c;
  logic [CW-1:0]   wr_idx_c;
  logic [KW-1:0]   wr_data_c;
  logic            cache_hit_c;

  assign kg_c     = key_gen(cnt_q, rk_q[cnt_q]);
  assign ptr_m1_c = ptr_q - CW'(1);

`ifdef INV_KEY_CACHE_EN
  logic          cache_vld_q;
  logic [KW-1:0] cache_key_q;

  assign cache_hit_c = cache_vld_q && (key_in == cache_key_q);

  // Capture the cipher key once its schedule is complete; any reset invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
    end else if (state_q == EXPAND && state_d == STREAM) begin
      cache_vld_q <= 1'b1;
      cache_key_q <= rk_q[0];
    end
  end
`else
  assign cache_hit_c = 1'b0;
`endif

  // Next-state, register-file write port and next output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    data_d    = data_q;
    round_d   = round_q;
    last_d    = last_q;
    wr_en_c   = 1'b0;
    wr_idx_c  = '0;
    wr_data_c = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (cache_hit_c) begin
            state_d = STREAM;
            ptr_d   = TOP_IDX;
            valid_d = 1'b1;
            data_d  = rk_q[TOP_IDX];
            round_d = 4'(NUM_ROUNDS);
            last_d  = 1'b0;
          end else begin
            state_d   = EXPAND;
            cnt_d     = '0;
            wr_en_c   = 1'b1;
            wr_idx_c  = '0;
            wr_data_c = key_in;
          end
        end
      end
      EXPAND: begin
        wr_en_c   = 1'b1;
        wr_idx_c  = cnt_q + CW'(1);
        wr_data_c = kg_c;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Newest key bypasses the register file so it is presented immediately.
          state_d = STREAM;
          ptr_d   = TOP_IDX;
          valid_d = 1'b1;
          data_d  = kg_c;
          round_d = 4'(NUM_ROUNDS);
          last_d  = 1'b0;
        end
      end
      STREAM: begin
        if (rk_ready) begin
          if (ptr_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            data_d  = '0;
            round_d = '0;
            last_d  = 1'b0;
          end else begin
            ptr_d   = ptr_m1_c;
            data_d  = rk_q[ptr_m1_c];
            round_d = 4'(ptr_m1_c);
            last_d  = (ptr_m1_c == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      round_q <= round_d;
      last_q  <= last_d;
    end
  end

  // Round-key register file; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) begin
      rk_q[wr_idx_c] <= wr_data_c;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_data  = data_q;
  assign rk_round = round_q;
  assign rk_last  = last_q;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Directed bench for inv_key_scheduler using FIPS-197 key-schedule vectors.
module tb_inv_key_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

`ifdef INV_KEY_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 11;
`endif

  logic [127:0] exp_a [0:10];

  always #5 clk = ~clk;

  inv_key_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_last  (rk_last)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle and return the cycle index of the first valid beat.
  task automatic start_key(input logic [127:0] k, output int lat);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
    lat    = 1;
    while (!rk_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Consume all eleven beats of key A with rk_ready high.
  task automatic drain_a(input string tag);
    rk_ready = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      chk({tag, "_round"}, 128'(rk_round), 128'(i));
      chk({tag, "_data"},  rk_data, exp_a[i]);
      chk({tag, "_last"},  128'(rk_last), 128'(i == 0));
      tick();
    end
    chk({tag, "_busy_end"},  128'(busy), 128'(0));
    chk({tag, "_valid_end"}, 128'(rk_valid), 128'(0));
    chk({tag, "_data_end"},  rk_data, 128'(0));
  endtask

  // Consume all eleven beats of key B, checking the known end points.
  task automatic drain_b(input string tag);
    rk_ready = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      chk({tag, "_round"}, 128'(rk_round), 128'(i));
      if (i == 10) chk({tag, "_r10"}, rk_data, B_R10);
      if (i == 0)  chk({tag, "_r0"},  rk_data, KEY_B);
      tick();
    end
    chk({tag, "_busy_end"}, 128'(busy), 128'(0));
  endtask

  initial begin
    int lat;
    int idx;
    int beats;
    int cyc;

    exp_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_data",  rk_data, 128'(0));
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_last",  128'(rk_last), 128'(0));

    // rst beats start in the same cycle; rk_ready while idle does nothing.
    start    = 1'b1;
    key_in   = KEY_A;
    rk_ready = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("prio_busy",  128'(busy), 128'(0));
    chk("prio_valid", 128'(rk_valid), 128'(0));

    // Basic expansion and back-to-back stream of key A.
    start_key(KEY_A, lat);
    chk("a_latency", 128'(lat), 128'(11));
    drain_a("a");

    // Back-to-back start of key B in the cycle after the last beat.
    start_key(KEY_B, lat);
    chk("b2b_latency", 128'(lat), 128'(11));
    drain_b("b2b");

    // Repeat key B: cached when the cache is built in.
    start_key(KEY_B, lat);
    chk("hit_latency", 128'(lat), 128'(HIT_LAT));
    drain_b("hit");

    // Key A with random backpressure: beats held while stalled, none lost.
    start_key(KEY_A, lat);
    chk("stall_latency", 128'(lat), 128'(11));
    idx   = 10;
    beats = 0;
    cyc   = 0;
    while (idx >= 0 && cyc < 300) begin
      rk_ready = 1'($urandom_range(0, 1));
      chk("stall_valid", 128'(rk_valid), 128'(1));
      chk("stall_round", 128'(rk_round), 128'(idx));
      chk("stall_data",  rk_data, exp_a[idx]);
      chk("stall_last",  128'(rk_last), 128'(idx == 0));
      if (rk_ready) begin
        beats++;
        idx--;
      end
      tick();
      cyc++;
    end
    chk("stall_beats", 128'(beats), 128'(11));
    chk("stall_busy_end", 128'(busy), 128'(0));
    chk("stall_valid_end", 128'(rk_valid), 128'(0));
    rk_ready = 1'b1;

    // A start of key B during streaming must be ignored.
    start_key(KEY_A, lat);
    chk("ign_latency", 128'(lat), 128'(HIT_LAT));
    for (int i = 10; i >= 0; i--) begin
      chk("ign_round", 128'(rk_round), 128'(i));
      chk("ign_data",  rk_data, exp_a[i]);
      if (i == 8) begin
        start  = 1'b1;
        key_in = KEY_B;
      end
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      chk("ign_no_extra_valid", 128'(rk_valid), 128'(0));
      chk("ign_no_extra_busy",  128'(busy), 128'(0));
      tick();
    end

    // Reset during expansion aborts it; a fresh start recovers normally.
    start  = 1'b1;
    key_in = KEY_B;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    chk("abort_busy_pre", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  128'(busy), 128'(0));
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_data",  rk_data, 128'(0));
    for (int k = 0; k < 12; k++) begin
      chk("abort_quiet", 128'(rk_valid), 128'(0));
      tick();
    end
    start_key(KEY_A, lat);
    chk("recover_latency", 128'(lat), 128'(11));
    drain_a("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
